// File: rtl/inst_mem_arbiter_pkg.sv
// rtl/inst_mem_arbiter_pkg.sv - shared types and constants for the instruction RAM arbiter
// Purpose: port tag enum, response-pipe entry type and the RAM geometry constants.
package inst_mem_arb_pkg;

  localparam int IMEM_ADDR_W = 13;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_BE_W   = 4;

  typedef enum logic {
    PORT_FETCH  = 1'b0,
    PORT_LOADER = 1'b1
  } port_t;

  // One slot of the read response pipeline: a read is in flight for 'port'.
  typedef struct packed {
    logic  valid;
    port_t port;
  } rsp_t;

  // The port that wins a tie when 'last' was the most recent grant.
  function automatic port_t other_port(input port_t last);
    return (last == PORT_FETCH) ? PORT_LOADER : PORT_FETCH;
  endfunction

endpackage

// File: rtl/inst_mem_arbiter_if.sv
// rtl/inst_mem_arbiter_if.sv - bus bundle between masters, arbiter and RAM wrapper
// Purpose: groups the fetch slave port, loader slave port and RAM master port.
// Modports:
//   slave  - arbiter view: takes f_*/l_* requests and m_readdata, drives the rest
//   master - environment view: fetch/loader masters plus the RAM wrapper
interface inst_mem_arbiter_if #(
  parameter int ADDR_W = inst_mem_arb_pkg::IMEM_ADDR_W,
  parameter int DATA_W = inst_mem_arb_pkg::IMEM_DATA_W,
  parameter int BE_W   = inst_mem_arb_pkg::IMEM_BE_W
) ();

  // fetch port (read-only)
  logic [ADDR_W-1:0] f_address;
  logic              f_read;
  logic              f_waitrequest;
  logic [DATA_W-1:0] f_readdata;
  logic              f_readdatavalid;

  // loader port (read/write)
  logic [ADDR_W-1:0] l_address;
  logic              l_read;
  logic              l_write;
  logic [DATA_W-1:0] l_writedata;
  logic [BE_W-1:0]   l_byteenable;
  logic              l_waitrequest;
  logic [DATA_W-1:0] l_readdata;
  logic              l_readdatavalid;

  // RAM side
  logic [ADDR_W-1:0] m_address;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  modport slave (
    input  f_address, f_read,
    input  l_address, l_read, l_write, l_writedata, l_byteenable,
    input  m_readdata,
    output f_waitrequest, f_readdata, f_readdatavalid,
    output l_waitrequest, l_readdata, l_readdatavalid,
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );

  modport master (
    output f_address, f_read,
    output l_address, l_read, l_write, l_writedata, l_byteenable,
    output m_readdata,
    input  f_waitrequest, f_readdata, f_readdatavalid,
    input  l_waitrequest, l_readdata, l_readdatavalid,
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );

endinterface

// File: rtl/inst_mem_arbiter_rsp_pipe.sv
// rtl/inst_mem_arbiter_rsp_pipe.sv - fixed-latency read response tag pipeline
// Purpose: DEPTH-deep shift register of {valid, port} with synchronous clear.
// Ports:
//   i_clk  - clock
//   i_clr  - synchronous clear, drops every in-flight entry
//   i_rsp  - entry pushed this cycle (valid=0 for no read)
//   o_rsp  - entry leaving the last stage
module imem_rsp_pipe
  import inst_mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_clr,
  input  rsp_t i_rsp,
  output rsp_t o_rsp
);

  localparam rsp_t RSP_EMPTY = '{valid: 1'b0, port: PORT_FETCH};

  rsp_t r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_stage[0] <= RSP_EMPTY;
    end else begin
      r_stage[0] <= i_rsp;
    end
  end

  for (genvar g = 1; g < DEPTH; g++) begin : g_stage
    always_ff @(posedge i_clk) begin
      if (i_clr) begin
        r_stage[g] <= RSP_EMPTY;
      end else begin
        r_stage[g] <= r_stage[g-1];
      end
    end
  end

  assign o_rsp = r_stage[DEPTH-1];

endmodule

// File: rtl/inst_mem_arbiter.sv
// rtl/inst_mem_arbiter.sv - round-robin share of the instruction RAM between fetch and loader
// Purpose: grants one access per cycle to the fetch or loader port, muxes it onto
//   the RAM and routes read data back through a fixed-latency tag pipeline.
// Ports:
//   i_clk       - system clock
//   i_reset     - synchronous active-high reset
//   i_boot_hold - 1 blocks the fetch port, loader gets exclusive access
//   bus         - fetch/loader slave ports and RAM master port (slave modport)
// Parameter READ_LATENCY (1..2): cycles from grant to m_readdata valid.
module inst_mem_arbiter
  import inst_mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_boot_hold,
  inst_mem_arbiter_if.slave    bus
);

  port_t r_last_grant;

  logic w_f_req;
  logic w_l_req;
  logic w_f_grant;
  logic w_l_grant;
  logic w_l_is_write;
  rsp_t w_push;
  rsp_t w_rsp_out;

  assign w_f_req = bus.f_read & ~i_boot_hold;
  assign w_l_req = bus.l_read | bus.l_write;
  // read+write together is treated as a write
  assign w_l_is_write = bus.l_write;

  // A lone requester wins; on a tie the port that did not win last time wins.
  // Reset suppresses all grants so waitrequest reads as 1 throughout reset.
  assign w_f_grant = ~i_reset & w_f_req &
                     (~w_l_req | (other_port(r_last_grant) == PORT_FETCH));
  assign w_l_grant = ~i_reset & w_l_req &
                     (~w_f_req | (other_port(r_last_grant) == PORT_LOADER));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= PORT_LOADER;
    end else if (w_f_grant) begin
      r_last_grant <= PORT_FETCH;
    end else if (w_l_grant) begin
      r_last_grant <= PORT_LOADER;
    end
  end

  assign bus.f_waitrequest = ~w_f_grant;
  assign bus.l_waitrequest = ~w_l_grant;

  // RAM mux: fetch address is the idle default
  assign bus.m_chipselect = w_f_grant | w_l_grant;
  assign bus.m_write      = w_l_grant & w_l_is_write;
  assign bus.m_address    = w_l_grant ? bus.l_address : bus.f_address;
  assign bus.m_byteenable = w_l_grant ? bus.l_byteenable : '1;
  assign bus.m_writedata  = w_l_grant ? bus.l_writedata : '0;
  assign bus.m_clken      = 1'b1;

  assign w_push.valid = w_f_grant | (w_l_grant & ~w_l_is_write);
  assign w_push.port  = w_l_grant ? PORT_LOADER : PORT_FETCH;

  imem_rsp_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rsp_pipe (
    .i_clk (i_clk),
    .i_clr (i_reset),
    .i_rsp (w_push),
    .o_rsp (w_rsp_out)
  );

  // Gated by reset so a response already in the last stage when reset
  // arrives never shows up on the ports.
  assign bus.f_readdatavalid = ~i_reset & w_rsp_out.valid & (w_rsp_out.port == PORT_FETCH);
  assign bus.l_readdatavalid = ~i_reset & w_rsp_out.valid & (w_rsp_out.port == PORT_LOADER);
  assign bus.f_readdata      = bus.m_readdata;
  assign bus.l_readdata      = bus.m_readdata;

endmodule
